// File: rtl/comparador_seq.sv
// comparador_seq: multi-cycle MSB-first chunked magnitude comparator; optional early exit via COMPARADOR_SAIDA_ANTECIPADA_EN
module comparador_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             com_sinal,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             RESULTADO,
  output logic             IGUAL,
  output logic             MENOR
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  if (WIDTH % CHUNK != 0) begin : g_chk
    $error("WIDTH must be a multiple of CHUNK");
  end
  typedef enum logic [1:0] {OCIOSO, COMPARANDO, CONCLUIDO} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [KW-1:0] k_q, k_d;
  logic [CHUNK-1:0] ca, cb;
  logic dif_q, dif_d, men_q, men_d, dif_n, men_n, last;
  logic ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic res_q, res_d, igual_q, igual_d, menor_q, menor_d;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    k_d = k_q;
    dif_d = dif_q;
    men_d = men_q;
    ready_d = ready_q;
    busy_d = busy_q;
    done_d = 1'b0;
    res_d = res_q;
    igual_d = igual_q;
    menor_d = menor_q;
    ca = a_q[WIDTH-1-CHUNK*int'(k_q) -: CHUNK];
    cb = b_q[WIDTH-1-CHUNK*int'(k_q) -: CHUNK];
    dif_n = dif_q | (ca != cb);
    men_n = dif_q ? men_q : (ca < cb);
`ifdef COMPARADOR_SAIDA_ANTECIPADA_EN
    last = dif_n || int'(k_q) == N - 1;
`else
    last = int'(k_q) == N - 1;
`endif
    if (state_q == OCIOSO && start) begin
      // signed compare becomes unsigned once both sign bits are flipped
      a_d = A ^ {com_sinal, {(WIDTH-1){1'b0}}};
      b_d = B ^ {com_sinal, {(WIDTH-1){1'b0}}};
      op_d = op;
      k_d = '0;
      dif_d = 1'b0;
      men_d = 1'b0;
      ready_d = 1'b0;
      busy_d = 1'b1;
      state_d = COMPARANDO;
    end else if (state_q == COMPARANDO) begin
      dif_d = dif_n;
      men_d = men_n;
      k_d = k_q + 1'b1;
      if (last) begin
        state_d = CONCLUIDO;
        busy_d = 1'b0;
        done_d = 1'b1;
        igual_d = !dif_n;
        menor_d = dif_n & men_n;
        res_d = op_q == 3'd0 ? !dif_n :
                op_q == 3'd1 ? dif_n :
                op_q == 3'd2 ? dif_n & men_n :
                op_q == 3'd3 ? !dif_n | men_n :
                op_q == 3'd4 ? dif_n & !men_n :
                op_q == 3'd5 ? !(dif_n & men_n) : 1'b0;
      end
    end else if (state_q == CONCLUIDO) begin
      state_d = OCIOSO;
      ready_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCIOSO;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      k_q <= '0;
      dif_q <= 1'b0;
      men_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q <= 1'b0;
      igual_q <= 1'b0;
      menor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      k_q <= k_d;
      dif_q <= dif_d;
      men_q <= men_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
      res_q <= res_d;
      igual_q <= igual_d;
      menor_q <= menor_d;
    end
  end
  assign ready = ready_q;
  assign busy = busy_q;
  assign done = done_q;
  assign RESULTADO = res_q;
  assign IGUAL = igual_q;
  assign MENOR = menor_q;
endmodule

// File: tb/tb_comparador_seq.sv
// tb_comparador_seq: directed scoreboard bench for comparador_seq (WIDTH=16, CHUNK=4)
module tb_comparador_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, com_sinal = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic [2:0] op = '0;
  logic ready, busy, done, RESULTADO, IGUAL, MENOR;
  int n_assert = 0, n_fail = 0, n_done = 0, exp_done = 0;
  typedef struct {logic res; logic ig; logic mn; int lat;} exp_t;
  exp_t sb[$];
  comparador_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .op(op), .com_sinal(com_sinal),
    .ready(ready), .busy(busy), .done(done), .RESULTADO(RESULTADO), .IGUAL(IGUAL), .MENOR(MENOR)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) n_done++;
  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o, input logic s);
    exp_t e;
    logic eq, lt;
    eq = a == b;
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
    case (o)
      3'd0: e.res = eq;
      3'd1: e.res = !eq;
      3'd2: e.res = lt;
      3'd3: e.res = lt | eq;
      3'd4: e.res = !(lt | eq);
      3'd5: e.res = !lt;
      default: e.res = 1'b0;
    endcase
    e.ig = eq;
    e.mn = lt;
    e.lat = 4;
`ifdef COMPARADOR_SAIDA_ANTECIPADA_EN
    for (int i = 3; i >= 0; i--) if (a[15-4*i -: 4] != b[15-4*i -: 4]) e.lat = i + 1;
`endif
    return e;
  endfunction
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o, input logic s);
    @(negedge clk);
    A = a; B = b; op = o; com_sinal = s; start = 1'b1;
    sb.push_back(model(a, b, o, s));
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int lat0);
    exp_t e;
    int lat = lat0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    exp_done++;
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_lat"}, lat, e.lat);
    check({tag, "_res"}, int'(RESULTADO), int'(e.res));
    check({tag, "_igual"}, int'(IGUAL), int'(e.ig));
    check({tag, "_menor"}, int'(MENOR), int'(e.mn));
    @(negedge clk);
    check({tag, "_pulse"}, int'(done), 0);
    check({tag, "_ready"}, int'(ready), 1);
  endtask
  initial begin
    logic r, ig, mn;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_flags", int'({done, RESULTADO, IGUAL, MENOR}), 0);
    drive(16'h1234, 16'h1234, 3'd3, 1'b0);
    check("busy_high", int'(busy), 1);
    wait_done("eq_le", 0);
    drive(16'h8000, 16'h0001, 3'd2, 1'b1); wait_done("lt_signed", 0);
    drive(16'h8000, 16'h0001, 3'd2, 1'b0); wait_done("lt_unsigned", 0);
    drive(16'h00FF, 16'h00FE, 3'd4, 1'b0); wait_done("gt_last", 0);
    drive(16'h0001, 16'h0002, 3'd5, 1'b0);
    A = 16'hFFFF; B = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ge_ignore", 1);
    check("ge_one_done", n_done, exp_done);
    drive(16'h1234, 16'h1234, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    check("abort_ready", int'(ready), 1);
    check("abort_outs", int'({busy, done, RESULTADO, IGUAL, MENOR}), 0);
    repeat (6) @(negedge clk);
    check("abort_no_done", n_done, exp_done);
    drive(16'd5, 16'd5, 3'd0, 1'b0); wait_done("eq_after_rst", 0);
    drive(16'd3, 16'd7, 3'd6, 1'b0); wait_done("reserved", 0);
    r = RESULTADO; ig = IGUAL; mn = MENOR;
    repeat (3) @(negedge clk);
    check("hold_flags", int'({RESULTADO, IGUAL, MENOR}), int'({r, ig, mn}));
    check("hold_menor", int'(MENOR), 1);
    for (int i = 0; i < 6; i++) begin
      drive(16'($urandom), (i % 2) ? 16'($urandom) : 16'h7F00, 3'(i), 1'(i / 3));
      wait_done("rand", 0);
    end
    check("done_total", n_done, exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
